neuron_seq_ctrl: RTL and testbench

NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

---
 rtl/neuron_seq_ctrl_pkg.sv | 13 +
 rtl/neuron_seq_ctrl_counter.sv | 38 +++
 rtl/neuron_seq_ctrl.sv | 95 +++++++++
 tb/tb_neuron_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_seq_ctrl_pkg.sv
// Shared accelerator definitions: neuron sequencer state encoding and default slot count.
package neuron_seq_ctrl_pkg;

    localparam int N_IN_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_seq_ctrl_counter.sv
// Slot index counter: synchronous clear, increment that folds back to 0 at the last slot.
module slot_counter #(
    parameter int N_IN  = 4,
    parameter int CNT_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc  = (cnt_q == CNT_W'(N_IN - 1));
    assign cnt = cnt_q;

    // Incrementing on the last slot returns to 0, so cnt never exceeds N_IN-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Neuron evaluation sequencer: loads N_IN operand slots, steps the MAC over them, holds the result.
module neuron_seq_ctrl
    import neuron_seq_ctrl_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int CNT_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_IN-1:0]  load_en,
    output logic             mac_en,
    output logic [CNT_W-1:0] mac_sel,
    output logic             mac_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_q;
    logic             mac_en_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;

    slot_counter #(
        .N_IN  (N_IN),
        .CNT_W (CNT_W)
    ) u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // abort wins over every other input in the cycle it is seen.
    always_comb begin
        accept  = (state_q == ST_LOAD) && in_valid && !abort;
        cnt_clr = abort || ((state_q == ST_IDLE) && start);
        cnt_inc = accept || ((state_q == ST_COMPUTE) && !abort);
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)            state_d = ST_LOAD;
            ST_LOAD:    if (accept && cnt_tc) state_d = ST_COMPUTE;
            ST_COMPUTE: if (cnt_tc)           state_d = ST_RESULT;
            ST_RESULT:  if (out_ready)        state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_LOAD);
            mac_en_q    <= (state_d == ST_COMPUTE);
            out_valid_q <= (state_d == ST_RESULT);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_load_en
            assign load_en[gi] = accept && (cnt == CNT_W'(gi));
        end
    endgenerate

    assign in_ready  = in_ready_q;
    assign mac_en    = mac_en_q;
    assign mac_sel   = mac_en_q ? cnt : '0;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // Clear strobe depends on live inputs, so it is masked while reset is held.
    assign mac_clr   = !reset && cnt_clr;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed and randomized checks of neuron_seq_ctrl against a transaction-level expectation.
module tb_neuron_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  load_en;
    logic          mac_en;
    logic [CW-1:0] mac_sel;
    logic          mac_clr;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    always #5 clk = ~clk;

    neuron_seq_ctrl #(.N_IN(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_en   (load_en),
        .mac_en    (mac_en),
        .mac_sel   (mac_sel),
        .mac_clr   (mac_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic b, input logic ir,
                            input logic [N-1:0] le, input logic me,
                            input logic [CW-1:0] ms, input logic mc, input logic ov);
        chk({tag, ".busy"},      32'(busy),      32'(b));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".load_en"},   32'(load_en),   32'(le));
        chk({tag, ".mac_en"},    32'(mac_en),    32'(me));
        chk({tag, ".mac_sel"},   32'(mac_sel),   32'(ms));
        chk({tag, ".mac_clr"},   32'(mac_clr),   32'(mc));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One evaluation from IDLE. Expectation: the load phase lasts until N operands are
    // offered, then exactly N compute cycles, then the result is held until out_ready.
    task automatic run_eval(input int gap_after, input int gap_len, input int rdy_delay,
                            input bit rnd, input bit hold_start, input int exp_lat);
        int acc = 0;
        int comp = 0;
        int res = 0;
        int gap = 0;
        int idle_gaps = 0;
        int first_ov = -1;
        int cyc = 0;
        bit done = 1'b0;
        start     = 1'b1;
        abort     = 1'b0;
        in_valid  = rnd ? 1'($urandom) : 1'b1;
        out_ready = rnd ? 1'($urandom) : 1'b1;
        @(negedge clk);
        chk_outs("idle_start", 0, 0, '0, 0, '0, 1, 0);
        next_cycle();
        while (!done && cyc < 200) begin
            cyc++;
            start = hold_start ? 1'b1 : (rnd ? 1'($urandom) : 1'b0);
            if (acc < N) begin
                if (rnd) begin
                    in_valid = ($urandom_range(0, 2) != 0);
                end else if (acc == gap_after && gap < gap_len) begin
                    in_valid = 1'b0;
                    gap++;
                end else begin
                    in_valid = 1'b1;
                end
            end else begin
                in_valid = rnd ? 1'($urandom) : 1'b1;
            end
            if (acc == N && comp == N) out_ready = (res >= rdy_delay);
            else                       out_ready = rnd ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
            if (acc < N) begin
                chk_outs("load", 1, 1, in_valid ? (N'(1) << acc) : '0, 0, '0, 0, 0);
                if (in_valid) acc++;
                else          idle_gaps++;
            end else if (comp < N) begin
                chk_outs("compute", 1, 0, '0, 1, CW'(comp), 0, 0);
                comp++;
            end else begin
                chk_outs("result", 1, 0, '0, 0, '0, 0, 1);
                if (out_ready) done = 1'b1;
                else           res++;
            end
            next_cycle();
        end
        chk("eval_completes", 32'(done), 32'd1);
        chk("latency", first_ov, 2 * N + 1 + idle_gaps);
        if (exp_lat >= 0) chk("latency_directed", first_ov, exp_lat);
        n_txn++;
        $display("[TB] txn %0d gaps=%0d rdy_delay=%0d latency=%0d", n_txn, idle_gaps, rdy_delay, first_ov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("reset", 0, 0, '0, 0, '0, 0, 0);
        reset = 1'b0;
        start = 1'b0;
        next_cycle();
        @(negedge clk);
        chk_outs("idle", 0, 0, '0, 0, '0, 0, 0);
        next_cycle();

        // Back-to-back load, immediate consumer.
        run_eval(-1, 0, 0, 1'b0, 1'b0, 9);
        // Three-cycle producer gap after the second accept.
        run_eval(2, 3, 0, 1'b0, 1'b0, 12);
        // Consumer stalls five cycles in RESULT.
        run_eval(-1, 0, 5, 1'b0, 1'b0, 9);

        // Abort in COMPUTE while slot 1 is presented.
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (N + 1) next_cycle();
        abort = 1'b1;
        @(negedge clk);
        chk_outs("abort_compute", 1, 0, '0, 1, CW'(1), 1, 0);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        chk_outs("abort_idle", 0, 0, '0, 0, '0, 0, 0);
        for (int i = 0; i < 2 * N; i++) begin
            next_cycle();
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        next_cycle();

        // Asynchronous reset between edges in the middle of LOAD.
        start = 1'b1; in_valid = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (2) next_cycle();
        start = 1'b1;
        #2 reset = 1'b1;
        #1 chk_outs("reset_async", 0, 0, '0, 0, '0, 0, 0);
        @(negedge clk);
        chk_outs("reset_held", 0, 0, '0, 0, '0, 0, 0);
        reset = 1'b0;
        start = 1'b0;
        next_cycle();
        run_eval(-1, 0, 0, 1'b0, 1'b0, 9);

        // start held through the RESULT handshake: back to IDLE first, then a new LOAD.
        run_eval(-1, 0, 0, 1'b0, 1'b1, 9);
        @(negedge clk);
        chk_outs("restart_idle", 0, 0, '0, 0, '0, 1, 0);
        next_cycle();
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        chk_outs("restart_load_abort", 1, 1, '0, 0, '0, 1, 0);
        next_cycle();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_outs("after_abort", 0, 0, '0, 0, '0, 0, 0);
        next_cycle();

        // Randomized producer gaps, consumer stalls and stray start pulses.
        for (int t = 0; t < 20; t++) begin
            run_eval(-1, 0, $urandom_range(0, 4), 1'b1, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
